// File: rtl/wb_write_queue.sv
// Register-file writeback queue: merges ALU and load writebacks in order, issues one write per cycle.
// Optional WB_STATS_EN adds saturating wr_count / stall_count outputs.
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [3:0]  mem_reg,
  input  logic [15:0] mem_data,
  input  logic        alu_valid,
  input  logic [3:0]  alu_reg,
  input  logic [15:0] alu_data,
  output logic        in_ready,
  output logic        write_reg,
  output logic [3:0]  dst_reg,
  output logic [15:0] dst_data,
  output logic [15:0] pend_mask,
  output logic        ovf
`ifdef WB_STATS_EN
  ,
  output logic [15:0] wr_count,
  output logic [15:0] stall_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [3:0]       ent_reg_q  [DEPTH];
  logic [15:0]      ent_data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] alu_slot;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             mem_enq, alu_enq, deq;
  logic [15:0]      pend_all;

  // Ready depends on count alone so sources never see a path through the dequeue.
  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));

  always_comb begin
    mem_enq  = mem_valid & in_ready & (mem_reg != 4'd0);
    alu_enq  = alu_valid & in_ready & (alu_reg != 4'd0);
    deq      = (count_q != '0);
    alu_slot = wr_ptr_q + PTR_W'(mem_enq);
    wr_ptr_d = wr_ptr_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    count_d  = count_q + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(deq);
    ovf_d    = ovf_q | ((mem_valid | alu_valid) & ~in_ready);
  end

  always_comb begin
    pend_all = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count_q) pend_all[ent_reg_q[rd_ptr_q + PTR_W'(i)]] = 1'b1;
    end
  end

  // Reset cycle suppresses issue so a stale head never reaches the register file.
  always_comb begin
    write_reg = deq & ~rst;
    dst_reg   = write_reg ? ent_reg_q[rd_ptr_q]  : 4'd0;
    dst_data  = write_reg ? ent_data_q[rd_ptr_q] : 16'd0;
    pend_mask = rst ? 16'd0 : pend_all;
  end

  assign ovf = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Mem entry takes wr_ptr, alu the following slot: the load is the older instruction.
  always_ff @(posedge clk) begin
    if (mem_enq) begin
      ent_reg_q[wr_ptr_q]  <= mem_reg;
      ent_data_q[wr_ptr_q] <= mem_data;
    end
    if (alu_enq) begin
      ent_reg_q[alu_slot]  <= alu_reg;
      ent_data_q[alu_slot] <= alu_data;
    end
  end

`ifdef WB_STATS_EN
  logic [15:0] wr_count_q, stall_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count_q    <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      if (write_reg && (wr_count_q != 16'hFFFF)) wr_count_q <= wr_count_q + 16'd1;
      if ((mem_valid | alu_valid) && !in_ready && (stall_count_q != 16'hFFFF))
        stall_count_q <= stall_count_q + 16'd1;
    end
  end

  assign wr_count    = wr_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: expected writes queued at drive time, popped as writes issue.
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [3:0]  mem_reg, alu_reg;
  logic [15:0] mem_data, alu_data;
  logic        in_ready, write_reg, ovf;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data, pend_mask;
`ifdef WB_STATS_EN
  logic [15:0] wr_count, stall_count;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [19:0] sb[$];
  logic [15:0] rf[16];

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .in_ready(in_ready), .write_reg(write_reg), .dst_reg(dst_reg),
    .dst_data(dst_data), .pend_mask(pend_mask), .ovf(ovf)
`ifdef WB_STATS_EN
    , .wr_count(wr_count), .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Every issued write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (write_reg === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got R%0d=%h required no write", dst_reg, dst_data);
      end else begin
        logic [19:0] exp_e;
        exp_e = sb.pop_front();
        if ({dst_reg, dst_data} !== exp_e) begin
          errors++;
          $display("FAIL write_order got R%0d=%h required R%0d=%h",
                   dst_reg, dst_data, exp_e[19:16], exp_e[15:0]);
        end
      end
      rf[dst_reg] = dst_data;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                       input logic av, input logic [3:0] ar, input logic [15:0] ad);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    if (in_ready === 1'b1) begin
      if (mv && mr != 4'd0) sb.push_back({mr, md});
      if (av && ar != 4'd0) sb.push_back({ar, ad});
    end
  endtask

  task automatic idle();
    mem_valid = 1'b0; alu_valid = 1'b0;
    mem_reg = 4'd0; alu_reg = 4'd0; mem_data = 16'd0; alu_data = 16'd0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (sb.size() == 0 && write_reg === 1'b0) break;
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL %s_drain got %0d pending required 0", name, sb.size());
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd2, 16'hBEEF, 1'b1, 4'd3, 16'hCAFE);
    sb.delete();
    step();
    step();
    @(negedge clk);
    checks++;
    if ({write_reg, pend_mask, in_ready, ovf, dst_reg, dst_data} !== {1'b0, 16'h0, 1'b1, 1'b0, 4'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset_state got wr=%b pend=%h rdy=%b ovf=%b dst=%h/%h required 0 0000 1 0 0/0000",
               write_reg, pend_mask, in_ready, ovf, dst_reg, dst_data);
    end
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (write_reg !== 1'b0 || pend_mask !== 16'h0) begin
      errors++;
      $display("FAIL reset_release got wr=%b pend=%h required 0 0000", write_reg, pend_mask);
    end
    step();
  endtask

  task automatic test_single();
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd3, 16'h1234);
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({write_reg, dst_reg, dst_data, pend_mask} !== {1'b1, 4'd3, 16'h1234, 16'h0008}) begin
      errors++;
      $display("FAIL single_issue got wr=%b R%0d=%h pend=%h required 1 R3=1234 pend=0008",
               write_reg, dst_reg, dst_data, pend_mask);
    end
    @(negedge clk);
    checks++;
    if (write_reg !== 1'b0 || pend_mask !== 16'h0) begin
      errors++;
      $display("FAIL single_clear got wr=%b pend=%h required 0 0000", write_reg, pend_mask);
    end
    step();
  endtask

  task automatic test_dual();
    drive(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'd5, 16'h5555);
    step();
    idle();
    @(negedge clk);
    checks++;
    if ({write_reg, dst_reg, dst_data, pend_mask} !== {1'b1, 4'd5, 16'hAAAA, 16'h0020}) begin
      errors++;
      $display("FAIL dual_first got wr=%b R%0d=%h pend=%h required 1 R5=aaaa pend=0020",
               write_reg, dst_reg, dst_data, pend_mask);
    end
    @(negedge clk);
    checks++;
    if ({write_reg, dst_reg, dst_data, pend_mask} !== {1'b1, 4'd5, 16'h5555, 16'h0020}) begin
      errors++;
      $display("FAIL dual_second got wr=%b R%0d=%h pend=%h required 1 R5=5555 pend=0020",
               write_reg, dst_reg, dst_data, pend_mask);
    end
    @(negedge clk);
    checks++;
    if (rf[5] !== 16'h5555 || write_reg !== 1'b0) begin
      errors++;
      $display("FAIL dual_final got R5=%h wr=%b required 5555 0", rf[5], write_reg);
    end
    step();
  endtask

  task automatic test_full_wrap();
    drive(1'b1, 4'd1, 16'h1111, 1'b1, 4'd2, 16'h2222);
    step();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_at_2 got %b required 1", in_ready);
    end
    drive(1'b1, 4'd3, 16'h3333, 1'b1, 4'd4, 16'h4444);
    step();
    idle();
    checks++;
    if (in_ready !== 1'b0 || pend_mask !== 16'h001C) begin
      errors++;
      $display("FAIL full_at_3 got rdy=%b pend=%h required 0 001c", in_ready, pend_mask);
    end
    wait_drain("full");
    for (int i = 0; i < 10; i++) begin
      int n = 0;
      while (in_ready !== 1'b1 && n < 20) begin step(); n++; end
      drive(1'b1, 4'($urandom_range(15, 1)), 16'($urandom),
            1'b1, 4'($urandom_range(15, 1)), 16'($urandom));
      step();
      idle();
    end
    wait_drain("burst");
    checks++;
    if (pend_mask !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL burst_empty got pend=%h rdy=%b required 0000 1", pend_mask, in_ready);
    end
  endtask

  task automatic test_r0_ovf();
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd0, 16'h7777);
    step();
    idle();
    @(negedge clk);
    checks++;
    if (write_reg !== 1'b0 || pend_mask !== 16'h0) begin
      errors++;
      $display("FAIL r0_filter got wr=%b pend=%h required 0 0000", write_reg, pend_mask);
    end
    step();
    drive(1'b1, 4'd6, 16'h0606, 1'b1, 4'd7, 16'h0707);
    step();
    drive(1'b1, 4'd8, 16'h0808, 1'b1, 4'd9, 16'h0909);
    step();
    checks++;
    if (ovf !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_ovf got ovf=%b rdy=%b required 0 0", ovf, in_ready);
    end
    drive(1'b0, 4'd0, 16'd0, 1'b1, 4'd10, 16'h0A0A);
    step();
    idle();
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b required 1", ovf);
    end
    wait_drain("ovf");
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_held got %b required 1", ovf);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b required 0", ovf);
    end
  endtask

  task automatic test_reset_mid_drain();
    drive(1'b1, 4'd11, 16'hB0B0, 1'b1, 4'd12, 16'hC0C0);
    step();
    drive(1'b1, 4'd13, 16'hD0D0, 1'b1, 4'd14, 16'hE0E0);
    step();
    idle();
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    checks++;
    if (write_reg !== 1'b0) begin
      errors++;
      $display("FAIL rst_cycle_write got %b required 0", write_reg);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({write_reg, pend_mask, in_ready} !== {1'b0, 16'h0, 1'b1}) begin
      errors++;
      $display("FAIL mid_drain_reset got wr=%b pend=%h rdy=%b required 0 0000 1",
               write_reg, pend_mask, in_ready);
    end
`ifdef WB_STATS_EN
    checks++;
    if (wr_count !== 16'd0 || stall_count !== 16'd0) begin
      errors++;
      $display("FAIL stats_reset got %0d/%0d required 0/0", wr_count, stall_count);
    end
`endif
    repeat (4) @(negedge clk);
    step();
  endtask

  initial begin
    for (int r = 0; r < 16; r++) rf[r] = 16'h0;
    idle();
    test_reset();
    test_single();
    test_dual();
    test_full_wrap();
    test_r0_ovf();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
